// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, iteration counter width, multiplier FSM states.
package alu_pkg;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/adder_32bit.sv
// 32-bit ripple-carry adder; the carry-out is the 33rd sum bit.
module adder_32bit
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] s,
  output logic              c
);

  logic [DATA_W:0] w_cy;

  always_comb begin
    w_cy    = '0;
    s       = '0;
    w_cy[0] = cin;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      s[i]      = a[i] ^ b[i] ^ w_cy[i];
      w_cy[i+1] = (a[i] & b[i]) | (w_cy[i] & (a[i] ^ b[i]));
    end
    c = w_cy[DATA_W];
  end

endmodule

// File: rtl/mul_seq_32bit.sv
// Sequential unsigned 32x32->64 shift-add multiplier sharing one ripple adder
// over 32 iterations, with valid/ready handshakes on operands and product.
module mul_seq_32bit
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] product,
  output logic        busy
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] w_sum;
  logic              w_cout;

  adder_32bit u_adder (
    .a   (r_hi),
    .b   (r_mcand),
    .cin (1'b0),
    .s   (w_sum),
    .c   (w_cout)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = RUN;
      RUN:     if (r_cnt == CNT_W'(DATA_W - 1)) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mcand <= a;
            r_hi    <= '0;
            r_lo    <= b;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          // {hi,lo} shifts right by one; the adder carry becomes hi's new MSB
          if (r_lo[0]) begin
            r_hi <= {w_cout, w_sum[DATA_W-1:1]};
            r_lo <= {w_sum[0], r_lo[DATA_W-1:1]};
          end else begin
            r_hi <= {1'b0, r_hi[DATA_W-1:1]};
            r_lo <= {r_hi[0], r_lo[DATA_W-1:1]};
          end
          r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == RUN);
  assign product   = {r_hi, r_lo};

endmodule

// File: tb/tb_mul_seq_32bit.sv
// Directed self-checking bench for mul_seq_32bit.
module tb_mul_seq_32bit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic        busy;

  int errors = 0;
  int checks = 0;

  mul_seq_32bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present an operand pair and return just after the acceptance edge.
  task automatic accept(input logic [31:0] av, input logic [31:0] bv);
    int n;
    @(negedge clk);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid rises (bounded); also count RUN cycles with busy low.
  task automatic wait_out(output int cycles, output int busy_gaps);
    cycles    = 0;
    busy_gaps = 0;
    while (cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
      if (out_valid) break;
      if (!busy) busy_gaps++;
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags: got in_ready/out_valid/busy=%b required 100", {in_ready, out_valid, busy});
    end
    checks++;
    if (product !== 64'h0) begin
      errors++;
      $display("FAIL reset_product: got %h required 0", product);
    end
  endtask

  task automatic test_basic;
    int cyc, gaps;
    out_ready = 1'b1;
    accept(32'd3, 32'd5);
    wait_out(cyc, gaps);
    checks++;
    if (cyc !== 32) begin
      errors++;
      $display("FAIL basic_latency: got %0d required 32", cyc);
    end
    checks++;
    if (product !== 64'h0F) begin
      errors++;
      $display("FAIL basic_product: got %h required 000000000000000f", product);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL basic_valid_one_cycle: got out_valid/in_ready=%b required 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_full_width;
    int cyc, gaps;
    out_ready = 1'b1;
    accept(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_out(cyc, gaps);
    checks++;
    if (product !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("FAIL full_width_product: got %h required fffffffe00000001", product);
    end
    checks++;
    if (cyc !== 32) begin
      errors++;
      $display("FAIL full_width_latency: got %0d required 32", cyc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero;
    int cyc, gaps;
    out_ready = 1'b1;
    accept(32'h0, 32'h1234_5678);
    wait_out(cyc, gaps);
    checks++;
    if (product !== 64'h0) begin
      errors++;
      $display("FAIL zero_product: got %h required 0", product);
    end
    checks++;
    if (cyc !== 32) begin
      errors++;
      $display("FAIL zero_latency: got %0d required 32", cyc);
    end
    checks++;
    if (gaps !== 0) begin
      errors++;
      $display("FAIL zero_busy: busy low in %0d RUN cycles, required 0", gaps);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure;
    int cyc, gaps;
    int bad;
    out_ready = 1'b0;
    accept(32'h8000_0000, 32'd2);
    wait_out(cyc, gaps);
    checks++;
    if (product !== 64'h1_0000_0000) begin
      errors++;
      $display("FAIL bp_product: got %h required 0000000100000000", product);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (product !== 64'h1_0000_0000 || !out_valid || in_ready) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d unstable cycles required 0", bad);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL bp_release: got in_ready/out_valid=%b required 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_input_ignored;
    int cyc, gaps;
    int extra;
    out_ready = 1'b1;
    accept(32'd6, 32'd7);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a        = 32'd7;
      b        = 32'd9;
      in_valid = ~in_valid;
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(cyc, gaps);
    checks++;
    if (product !== 64'd42) begin
      errors++;
      $display("FAIL ignored_first: got %0d required 42", product);
    end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL ignored_no_second: got %0d active cycles required 0", extra);
    end
    accept(32'd7, 32'd9);
    wait_out(cyc, gaps);
    checks++;
    if (product !== 64'd63) begin
      errors++;
      $display("FAIL ignored_second: got %0d required 63", product);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_op;
    int cyc, gaps;
    int stale;
    out_ready = 1'b1;
    accept(32'd3, 32'd5);
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL midreset_flags: got %b required 100", {in_ready, out_valid, busy});
    end
    checks++;
    if (product !== 64'h0) begin
      errors++;
      $display("FAIL midreset_product: got %h required 0", product);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    checks++;
    if (stale !== 0) begin
      errors++;
      $display("FAIL midreset_stale_valid: got %0d cycles required 0", stale);
    end
    accept(32'd12345, 32'd1000);
    wait_out(cyc, gaps);
    checks++;
    if (product !== 64'hBC_5EA8 || cyc !== 32) begin
      errors++;
      $display("FAIL midreset_fresh: got %h after %0d required 0000000000bc5ea8 after 32", product, cyc);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    test_basic;
    test_full_width;
    test_zero;
    test_backpressure;
    test_input_ignored;
    test_reset_mid_op;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
